// File: rtl/uart_param.sv
// UART transceiver: FIFO-fed transmitter, 16x-oversampled majority-vote receiver and internal loopback.
// Writes to a full TX FIFO are dropped; an unread RX word is kept and later frames raise Rx_OVERRUN.
module uart_param #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        baud_select,
  input  logic              Tx_EN,
  input  logic              Rx_EN,
  input  logic              loopback,
  input  logic [DATA_W-1:0] Tx_DATA,
  input  logic              Tx_WR,
  output logic              Tx_FULL,
  output logic              Tx_BUSY,
  output logic              TxD,
  input  logic              RxD,
  output logic [DATA_W-1:0] Rx_DATA,
  output logic              Rx_VALID,
  input  logic              Rx_RD,
  output logic              Rx_FERROR,
  output logic              Rx_PERROR,
  output logic              Rx_OVERRUN
);

  localparam int DIV0 = (CLK_HZ + 8 * 300) / (16 * 300);
  localparam int DIV1 = (CLK_HZ + 8 * 1200) / (16 * 1200);
  localparam int DIV2 = (CLK_HZ + 8 * 4800) / (16 * 4800);
  localparam int DIV3 = (CLK_HZ + 8 * 9600) / (16 * 9600);
  localparam int DIV4 = (CLK_HZ + 8 * 19200) / (16 * 19200);
  localparam int DIV5 = (CLK_HZ + 8 * 38400) / (16 * 38400);
  localparam int DIV6 = (CLK_HZ + 8 * 57600) / (16 * 57600);
  localparam int DIV7 = (CLK_HZ + 8 * 115200) / (16 * 115200);
  localparam int CW   = $clog2(DIV0 + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BW   = $clog2(DATA_W);

  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [4:0]    STOP_END  = 5'(16 * STOP_BITS - 1);
  localparam logic          PODD      = (PARITY_ODD != 0);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- baud tick ----------------
  logic [CW-1:0] div_sel, bcnt_q, bcnt_d;
  logic [2:0]    bsel_q;
  logic          tick;

  always_comb begin
    case (baud_select)
      3'd0:    div_sel = CW'(DIV0);
      3'd1:    div_sel = CW'(DIV1);
      3'd2:    div_sel = CW'(DIV2);
      3'd3:    div_sel = CW'(DIV3);
      3'd4:    div_sel = CW'(DIV4);
      3'd5:    div_sel = CW'(DIV5);
      3'd6:    div_sel = CW'(DIV6);
      default: div_sel = CW'(DIV7);
    endcase
  end

  assign tick = (bcnt_q == div_sel - 1'b1) && (baud_select == bsel_q);

  always_comb begin
    bcnt_d = tick ? '0 : bcnt_q + 1'b1;
    if (baud_select != bsel_q) bcnt_d = '0;
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push, pop;

  assign Tx_FULL = (cnt_q == FULL_CNT);
  assign push    = Tx_WR && !Tx_FULL;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= Tx_DATA;
  end

  // ---------------- TX FSM ----------------
  state_t            tx_state_q, tx_state_d;
  logic [4:0]        tx_tick_q, tx_tick_d;
  logic [BW-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_line;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_line    = 1'b1;
    pop        = 1'b0;
    if (tick) tx_tick_d = tx_tick_q + 5'd1;
    case (tx_state_q)
      S_IDLE: begin
        tx_tick_d = '0;
        if (tick && cnt_q != '0 && Tx_EN) begin
          pop        = 1'b1;
          tx_sh_d    = mem_q[rptr_q];
          tx_par_d   = (^mem_q[rptr_q]) ^ PODD;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (tick && tx_tick_q == 5'd15) begin
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_line = tx_sh_q[0];
        if (tick && tx_tick_q == 5'd15) begin
          tx_tick_d = '0;
          tx_sh_d   = tx_sh_q >> 1;
          if (tx_bit_q == LAST_BIT) tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else                      tx_bit_d   = tx_bit_q + 1'b1;
        end
      end
      S_PARITY: begin
        tx_line = tx_par_q;
        if (tick && tx_tick_q == 5'd15) begin
          tx_tick_d  = '0;
          tx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick && tx_tick_q == STOP_END) tx_state_d = S_IDLE;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Line is decoded from state so an asynchronous reset drives it high immediately.
  assign TxD     = loopback ? 1'b1 : tx_line;
  assign Tx_BUSY = (cnt_q != '0) || (tx_state_q != S_IDLE);

  // ---------------- RX path ----------------
  logic              sync1_q, sync2_q, rx_s;
  state_t            rx_state_q, rx_state_d;
  logic [3:0]        rx_ph_q, rx_ph_d;
  logic [BW-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic              rx_s7_q, rx_s7_d, rx_s8_q, rx_s8_d;
  logic              rx_fe_q, rx_fe_d, rx_pe_q, rx_pe_d, rx_fe_new;
  logic              rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;
  logic              rx_perr_q, rx_perr_d, rx_ovr_q, rx_ovr_d;
  logic              rx_maj, rx_smp, rx_end, rx_done;

  assign rx_s      = sync2_q;
  assign rx_maj    = (rx_s7_q & rx_s8_q) | (rx_s7_q & rx_s) | (rx_s8_q & rx_s);
  assign rx_smp    = tick && rx_ph_q == 4'd9;
  assign rx_end    = tick && rx_ph_q == 4'd15;
  assign rx_fe_new = rx_fe_q | ~rx_maj;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_ph_d    = rx_ph_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_s7_d    = rx_s7_q;
    rx_s8_d    = rx_s8_q;
    rx_fe_d    = rx_fe_q;
    rx_pe_d    = rx_pe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ferr_d  = rx_ferr_q;
    rx_perr_d  = rx_perr_q;
    rx_ovr_d   = rx_ovr_q;
    rx_done    = 1'b0;
    if (tick) begin
      rx_ph_d = rx_ph_q + 4'd1;
      if (rx_ph_q == 4'd7) rx_s7_d = rx_s;
      if (rx_ph_q == 4'd8) rx_s8_d = rx_s;
    end
    case (rx_state_q)
      S_IDLE: begin
        rx_ph_d = '0;
        if (!rx_s) begin
          rx_state_d = S_START;
          rx_bit_d   = '0;
          rx_fe_d    = 1'b0;
          rx_pe_d    = 1'b0;
        end
      end
      S_START: begin
        if (rx_smp && rx_maj) rx_state_d = S_IDLE;
        else if (rx_end)      rx_state_d = S_DATA;
      end
      S_DATA: begin
        if (rx_smp) rx_sh_d = {rx_maj, rx_sh_q[DATA_W-1:1]};
        if (rx_end) begin
          if (rx_bit_q == LAST_BIT) begin
            rx_bit_d   = '0;
            rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (rx_smp) rx_pe_d = rx_maj ^ (^rx_sh_q) ^ PODD;
        if (rx_end) rx_state_d = S_STOP;
      end
      S_STOP: begin
        if (rx_smp) begin
          rx_fe_d = rx_fe_new;
          if (rx_bit_q == LAST_STOP) begin
            rx_done    = 1'b1;
            rx_state_d = S_IDLE;
          end
        end else if (rx_end) begin
          rx_bit_d = rx_bit_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
    if (!Rx_EN) begin
      rx_state_d = S_IDLE;
      rx_done    = 1'b0;
    end
    if (Rx_RD) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
    // A completion coinciding with the acknowledge still loads the new word.
    if (rx_done) begin
      if (!rx_valid_q || Rx_RD) begin
        rx_data_d  = rx_sh_q;
        rx_ferr_d  = rx_fe_new;
        rx_perr_d  = rx_pe_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  assign Rx_DATA    = rx_data_q;
  assign Rx_VALID   = rx_valid_q;
  assign Rx_FERROR  = rx_ferr_q;
  assign Rx_PERROR  = rx_perr_q;
  assign Rx_OVERRUN = rx_ovr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q     <= '0;
      bsel_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      tx_state_q <= S_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_ph_q    <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_s7_q    <= 1'b1;
      rx_s8_q    <= 1'b1;
      rx_fe_q    <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      bcnt_q     <= bcnt_d;
      bsel_q     <= baud_select;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q      <= cnt_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      sync1_q    <= loopback ? tx_line : RxD;
      sync2_q    <= sync1_q;
      rx_state_q <= rx_state_d;
      rx_ph_q    <= rx_ph_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_s7_q    <= rx_s7_d;
      rx_s8_q    <= rx_s8_d;
      rx_fe_q    <= rx_fe_d;
      rx_pe_q    <= rx_pe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_perr_q  <= rx_perr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

endmodule
